// File: rtl/game_timer_ctrl.sv
// Round countdown timer: a reloadable 1 Hz prescaler feeding an idle/run/pause/done FSM.
// Provides seconds remaining in binary and BCD, a low-time warning and a timeout pulse.
module game_timer_ctrl #(
    parameter int TICKS_PER_SEC = 50000000,
    parameter int TIME_LIMIT    = 99,
    parameter int WARN_SECS     = 10
) (
    input  logic        clock,
    input  logic        resetn,
    input  logic        start,
    input  logic        pause,
    input  logic        abort,
    output logic [6:0]  secs_left,
    output logic [3:0]  bcd_tens,
    output logic [3:0]  bcd_ones,
    output logic        running,
    output logic        paused,
    output logic        expired,
    output logic        tick,
    output logic        timeout,
    output logic        warn,
    output logic [1:0]  state_dbg,
    output logic [25:0] prescaler_dbg
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_PAUSE = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    localparam logic [25:0] RELOAD     = 26'(TICKS_PER_SEC - 1);
    localparam logic [6:0]  LIMIT      = 7'(TIME_LIMIT);
    localparam logic [6:0]  WARN_LIMIT = 7'(WARN_SECS);
    localparam logic [3:0]  LIMIT_TENS = 4'(TIME_LIMIT / 10);
    localparam logic [3:0]  LIMIT_ONES = 4'(TIME_LIMIT % 10);

    state_t      state;
    logic [25:0] prescaler;

    state_t      state_n;
    logic [25:0] prescaler_n;
    logic [6:0]  secs_n;
    logic        tick_n;
    logic        timeout_n;
    logic        warn_n;
    logic [3:0]  tens_n;
    logic [3:0]  ones_n;

    // Next-state logic; every registered output is derived from these values so
    // BCD and warn always agree with secs_left on the same cycle.
    always_comb begin
        state_n     = state;
        prescaler_n = prescaler;
        secs_n      = secs_left;
        tick_n      = 1'b0;
        timeout_n   = 1'b0;

        if (abort) begin
            state_n     = S_IDLE;
            secs_n      = LIMIT;
            prescaler_n = RELOAD;
        end else begin
            case (state)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        state_n     = S_RUN;
                        secs_n      = LIMIT;
                        prescaler_n = RELOAD;
                    end
                end
                S_RUN: begin
                    // Entering pause freezes the prescaler, even when it sits at zero.
                    if (pause) begin
                        state_n = S_PAUSE;
                    end else if (prescaler == 26'd0) begin
                        prescaler_n = RELOAD;
                        tick_n      = 1'b1;
                        if (secs_left <= 7'd1) begin
                            state_n   = S_DONE;
                            secs_n    = 7'd0;
                            timeout_n = 1'b1;
                        end else begin
                            secs_n = secs_left - 7'd1;
                        end
                    end else begin
                        prescaler_n = prescaler - 26'd1;
                    end
                end
                S_PAUSE: begin
                    // Resume from the held prescaler value; no decrement on this edge.
                    if (!pause) begin
                        state_n = S_RUN;
                    end
                end
                default: begin
                    state_n = S_IDLE;
                end
            endcase
        end

        warn_n = ((state_n == S_RUN) || (state_n == S_PAUSE)) &&
                 (secs_n >= 7'd1) && (secs_n <= WARN_LIMIT);
        tens_n = 4'(secs_n / 7'd10);
        ones_n = 4'(secs_n % 7'd10);
    end

    always_ff @(posedge clock) begin
        if (!resetn) begin
            state     <= S_IDLE;
            prescaler <= RELOAD;
            secs_left <= LIMIT;
            bcd_tens  <= LIMIT_TENS;
            bcd_ones  <= LIMIT_ONES;
            running   <= 1'b0;
            paused    <= 1'b0;
            expired   <= 1'b0;
            tick      <= 1'b0;
            timeout   <= 1'b0;
            warn      <= 1'b0;
        end else begin
            state     <= state_n;
            prescaler <= prescaler_n;
            secs_left <= secs_n;
            bcd_tens  <= tens_n;
            bcd_ones  <= ones_n;
            running   <= (state_n == S_RUN) || (state_n == S_PAUSE);
            paused    <= (state_n == S_PAUSE);
            expired   <= (state_n == S_DONE);
            tick      <= tick_n;
            timeout   <= timeout_n;
            warn      <= warn_n;
        end
    end

    assign state_dbg     = state;
    assign prescaler_dbg = prescaler;

endmodule

// File: tb/tb_game_timer_ctrl.sv
// Directed bench for game_timer_ctrl: small build (4 ticks/s, 3 s limit, warn at 2)
// plus a 99-second build for the two-digit BCD case.
module tb_game_timer_ctrl;

    logic        clock = 1'b0;
    logic        resetn = 1'b0;
    logic        start = 1'b0;
    logic        pause = 1'b0;
    logic        abort = 1'b0;
    logic [6:0]  secs_left;
    logic [3:0]  bcd_tens, bcd_ones;
    logic        running, paused, expired, tick, timeout, warn;
    logic [1:0]  state_dbg;
    logic [25:0] prescaler_dbg;

    logic        start_b = 1'b0;
    logic [6:0]  secs_b;
    logic [3:0]  tens_b, ones_b;
    logic        running_b, paused_b, expired_b, tick_b, timeout_b, warn_b;
    logic [1:0]  state_b;
    logic [25:0] prescaler_b;

    int total = 0;
    int bad   = 0;

    logic [6:0]  exp_secs;
    logic [25:0] exp_pre;
    logic        exp_tick, exp_warn, exp_to;

    game_timer_ctrl #(.TICKS_PER_SEC(4), .TIME_LIMIT(3), .WARN_SECS(2)) u_dut (
        .clock(clock), .resetn(resetn), .start(start), .pause(pause), .abort(abort),
        .secs_left(secs_left), .bcd_tens(bcd_tens), .bcd_ones(bcd_ones),
        .running(running), .paused(paused), .expired(expired), .tick(tick),
        .timeout(timeout), .warn(warn), .state_dbg(state_dbg), .prescaler_dbg(prescaler_dbg)
    );

    game_timer_ctrl #(.TICKS_PER_SEC(4), .TIME_LIMIT(99), .WARN_SECS(10)) u_big (
        .clock(clock), .resetn(resetn), .start(start_b), .pause(1'b0), .abort(1'b0),
        .secs_left(secs_b), .bcd_tens(tens_b), .bcd_ones(ones_b),
        .running(running_b), .paused(paused_b), .expired(expired_b), .tick(tick_b),
        .timeout(timeout_b), .warn(warn_b), .state_dbg(state_b), .prescaler_dbg(prescaler_b)
    );

    always #5 clock = ~clock;

    // Advance one active edge and settle; inputs set after this are seen on the next edge.
    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic start_round();
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    task automatic do_abort();
        abort = 1'b1;
        step();
        abort = 1'b0;
    endtask

    task automatic test_reset();
        resetn = 1'b0;
        step();
        step();
        resetn = 1'b1;
        total++; if (secs_left !== 7'd3) begin bad++; $display("FAIL reset_secs got=%0d want=3", secs_left); end
        total++; if ({bcd_tens, bcd_ones} !== 8'h03) begin bad++; $display("FAIL reset_bcd got=%h want=03", {bcd_tens, bcd_ones}); end
        total++; if ({running, paused, expired, tick, timeout, warn} !== 6'b0) begin bad++; $display("FAIL reset_flags got=%b want=000000", {running, paused, expired, tick, timeout, warn}); end
        total++; if (prescaler_dbg !== 26'd3) begin bad++; $display("FAIL reset_prescaler got=%0d want=3", prescaler_dbg); end
        total++; if (state_dbg !== 2'd0) begin bad++; $display("FAIL reset_state got=%0d want=0", state_dbg); end
        total++; if ({tens_b, ones_b} !== 8'h99 || secs_b !== 7'd99) begin bad++; $display("FAIL reset_big got=%h/%0d want=99/99", {tens_b, ones_b}, secs_b); end
    endtask

    task automatic test_countdown();
        start_round();
        total++; if (running !== 1'b1 || secs_left !== 7'd3 || warn !== 1'b0 || prescaler_dbg !== 26'd3) begin
            bad++; $display("FAIL cd_start run=%b secs=%0d warn=%b pre=%0d want 1/3/0/3", running, secs_left, warn, prescaler_dbg);
        end
        for (int k = 1; k <= 12; k++) begin
            step();
            exp_secs = 7'(3 - k / 4);
            exp_pre  = 26'(3 - k % 4);
            exp_tick = (k % 4 == 0);
            exp_warn = (exp_secs == 7'd1) || (exp_secs == 7'd2);
            exp_to   = (k == 12);
            total++; if (secs_left !== exp_secs || bcd_ones !== exp_secs[3:0] || bcd_tens !== 4'd0) begin
                bad++; $display("FAIL cd_secs edge=%0d got=%0d bcd=%h want=%0d", k, secs_left, {bcd_tens, bcd_ones}, exp_secs);
            end
            total++; if (tick !== exp_tick || timeout !== exp_to || expired !== exp_to) begin
                bad++; $display("FAIL cd_pulse edge=%0d tick=%b to=%b exp=%b want %b/%b/%b", k, tick, timeout, expired, exp_tick, exp_to, exp_to);
            end
            total++; if (warn !== exp_warn) begin bad++; $display("FAIL cd_warn edge=%0d got=%b want=%b", k, warn, exp_warn); end
            total++; if (prescaler_dbg !== exp_pre) begin bad++; $display("FAIL cd_pre edge=%0d got=%0d want=%0d", k, prescaler_dbg, exp_pre); end
        end
        step();
        total++; if (timeout !== 1'b0 || tick !== 1'b0 || expired !== 1'b1 || secs_left !== 7'd0 || running !== 1'b0) begin
            bad++; $display("FAIL cd_done_hold to=%b tick=%b exp=%b secs=%0d run=%b want 0/0/1/0/0", timeout, tick, expired, secs_left, running);
        end
    endtask

    task automatic test_pause();
        start_round();
        step();
        step();
        pause = 1'b1;
        for (int k = 3; k <= 12; k++) begin
            step();
            total++; if (paused !== 1'b1 || running !== 1'b1 || tick !== 1'b0 || prescaler_dbg !== 26'd1 || secs_left !== 7'd3) begin
                bad++; $display("FAIL pause_hold edge=%0d paused=%b run=%b tick=%b pre=%0d secs=%0d want 1/1/0/1/3", k, paused, running, tick, prescaler_dbg, secs_left);
            end
        end
        pause = 1'b0;
        step();
        total++; if (paused !== 1'b0 || running !== 1'b1 || prescaler_dbg !== 26'd1 || tick !== 1'b0) begin
            bad++; $display("FAIL pause_resume paused=%b run=%b pre=%0d tick=%b want 0/1/1/0", paused, running, prescaler_dbg, tick);
        end
        step();
        total++; if (tick !== 1'b0 || prescaler_dbg !== 26'd0) begin bad++; $display("FAIL pause_r1 tick=%b pre=%0d want 0/0", tick, prescaler_dbg); end
        step();
        total++; if (tick !== 1'b1 || secs_left !== 7'd2 || warn !== 1'b1) begin
            bad++; $display("FAIL pause_r2 tick=%b secs=%0d warn=%b want 1/2/1", tick, secs_left, warn);
        end
        do_abort();
    endtask

    task automatic test_abort();
        start_round();
        for (int k = 1; k <= 11; k++) step();
        total++; if (secs_left !== 7'd1 || prescaler_dbg !== 26'd0) begin
            bad++; $display("FAIL abort_setup secs=%0d pre=%0d want 1/0", secs_left, prescaler_dbg);
        end
        do_abort();
        total++; if (secs_left !== 7'd3 || {bcd_tens, bcd_ones} !== 8'h03 || state_dbg !== 2'd0) begin
            bad++; $display("FAIL abort_secs secs=%0d bcd=%h st=%0d want 3/03/0", secs_left, {bcd_tens, bcd_ones}, state_dbg);
        end
        total++; if ({running, expired, tick, timeout, warn} !== 5'b0 || prescaler_dbg !== 26'd3) begin
            bad++; $display("FAIL abort_flags flags=%b pre=%0d want 00000/3", {running, expired, tick, timeout, warn}, prescaler_dbg);
        end
    endtask

    task automatic test_start_ignored();
        start_round();
        for (int k = 1; k <= 12; k++) begin
            start = (k == 2) || (k == 5) || (k == 6) || (k == 9);
            step();
            exp_tick = (k % 4 == 0);
            exp_secs = 7'(3 - k / 4);
            total++; if (tick !== exp_tick || secs_left !== exp_secs) begin
                bad++; $display("FAIL ign_tick edge=%0d tick=%b secs=%0d want %b/%0d", k, tick, secs_left, exp_tick, exp_secs);
            end
        end
        start = 1'b0;
        total++; if (expired !== 1'b1) begin bad++; $display("FAIL ign_done got=%b want=1", expired); end
        start_round();
        total++; if (expired !== 1'b0 || secs_left !== 7'd3 || running !== 1'b1 || timeout !== 1'b0) begin
            bad++; $display("FAIL restart exp=%b secs=%0d run=%b to=%b want 0/3/1/0", expired, secs_left, running, timeout);
        end
        do_abort();
    endtask

    task automatic test_reset_mid();
        start_round();
        for (int k = 1; k <= 7; k++) step();
        total++; if (secs_left !== 7'd2 || warn !== 1'b1) begin bad++; $display("FAIL rmid_setup secs=%0d warn=%b want 2/1", secs_left, warn); end
        resetn = 1'b0;
        step();
        resetn = 1'b1;
        total++; if (secs_left !== 7'd3 || {bcd_tens, bcd_ones} !== 8'h03 || prescaler_dbg !== 26'd3 || state_dbg !== 2'd0) begin
            bad++; $display("FAIL rmid_vals secs=%0d bcd=%h pre=%0d st=%0d want 3/03/3/0", secs_left, {bcd_tens, bcd_ones}, prescaler_dbg, state_dbg);
        end
        total++; if ({running, paused, expired, tick, timeout, warn} !== 6'b0) begin
            bad++; $display("FAIL rmid_flags got=%b want=000000", {running, paused, expired, tick, timeout, warn});
        end
    endtask

    task automatic test_bcd99();
        start_b = 1'b1;
        step();
        start_b = 1'b0;
        total++; if ({tens_b, ones_b} !== 8'h99 || secs_b !== 7'd99 || running_b !== 1'b1 || warn_b !== 1'b0) begin
            bad++; $display("FAIL big_start bcd=%h secs=%0d run=%b warn=%b want 99/99/1/0", {tens_b, ones_b}, secs_b, running_b, warn_b);
        end
        for (int k = 1; k <= 4; k++) step();
        total++; if ({tens_b, ones_b} !== 8'h98 || secs_b !== 7'd98 || tick_b !== 1'b1) begin
            bad++; $display("FAIL big_tick bcd=%h secs=%0d tick=%b want 98/98/1", {tens_b, ones_b}, secs_b, tick_b);
        end
    endtask

    initial begin
        test_reset();
        test_countdown();
        test_pause();
        test_abort();
        test_start_ignored();
        test_reset_mid();
        test_bcd99();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
